axis_1553_encoder_mc: RTL and testbench
=======================================

Name: axis_1553_encoder_mc

Overview:
Parametrised multi-bus MIL-STD-1553 Manchester II encoder with an AXI-Stream slave input. It is the next generation of axis_1553_encoder and adds:
- selectable bus count (dual-redundant A/B or more)
- a programmable inter-word gap
- parity-error injection
- contiguous back-to-back word transmission

Each accepted 16-bit word is sent as one 20-bit-time frame (sync, data, odd parity) on the differential pair chosen by tuser.

Parameters:
clock_speed, 20000000, aclk frequency in Hz
data_rate, 1000000, bus bit rate in bit/s; clock_speed/(2*data_rate) must be an integer >= 2, otherwise elaboration fails with $error
NUM_BUS, 2, number of differential outputs, 1..4

Ports:
aclk  in  1  clock
arst  in  1  synchronous active-high reset
s_axis_tdata  in  16  word to transmit, MSB first
s_axis_tvalid  in  1  word valid
s_axis_tuser  in  8  [7] sync type (1 = command/status, 0 = data); [6] invert parity; [5:4] bus select; [3:0] gap after word, in bit times
s_axis_tready  out  1  encoder can accept a word this cycle
diff  out  2*NUM_BUS  per bus {pos,neg}: 10 = high half-bit, 01 = low half-bit, 00 = idle
en_diff  out  NUM_BUS  transceiver enable per bus
drop  out  1  one-cycle pulse: word accepted but discarded because bus select >= NUM_BUS

Behaviour:
- Only one clock (aclk). Reset is synchronous and active-high on arst.
- While arst is high: state IDLE, diff=0, en_diff=0, tready=0, drop=0, all counters 0. tready rises on the first cycle after arst falls.
- Half-bit period is H = clock_speed/(2*data_rate) cycles (H = 10 at defaults). A frame is 40 half-bits (40*H cycles).
- All outputs are registered.
- States:
  - IDLE: tready=1, diff=0, en_diff=0. On tvalid&tready, latch tdata/tuser and go to SYNC.
  - SYNC: 6 half-bits. Command sync = 3 high then 3 low; data sync = 3 low then 3 high.
  - DATA: 16 bits, MSB first. Bit 1 = high then low; bit 0 = low then high.
  - PARITY: 1 bit encoded like DATA. Parity value = (~^data) ^ tuser[6], i.e. odd parity unless inverted.
  - GAP: tuser[3:0]*H*2 cycles with diff=0 and en_diff=0. Skipped entirely when the gap is 0.
- Latency: handshake in cycle N; diff and en_diff for the selected bus are driven from cycle N+1.
- en_diff[sel] is high for exactly 40*H cycles per word. Unselected buses stay 00/0.
- Contiguous words: tready is also 1 in the last cycle of PARITY when gap=0, and in the last cycle of GAP.
  - A handshake there starts the next SYNC on the next cycle, with no idle cycle; en_diff stays high across the boundary.
  - A new word may select a different bus. The old bus drops en_diff on the same cycle the new bus raises it.
- If no word is offered at the end of PARITY or GAP, return to IDLE.
- Bus select >= NUM_BUS:
  - word is accepted;
  - drop pulses in cycle N+1;
  - nothing is transmitted;
  - the encoder stays in IDLE.
- tvalid without tready: the word is held upstream; the latched word is never modified mid-frame.
- arst mid-frame: outputs go to idle on the next edge, the frame is abandoned, and it is not resumed.

Decomposition:
- Package axis_1553_pkg holds:
  - state enum (IDLE, SYNC, DATA, PARITY, GAP)
  - half-bit counts SYNC_HALF=6, DATA_HALF=32, PARITY_HALF=2
  - tuser field bit positions
  - diff symbol constants DIFF_HI=2'b10, DIFF_LO=2'b01, DIFF_IDLE=2'b00
- One sub-module, mil1553_halfbit_tick:
  - counter parameterised by H;
  - emits a one-cycle tick at each half-bit boundary plus a last-cycle flag;
  - cleared whenever a frame starts.

Test Plan:
1. Reset: arst high 5 cycles with tvalid=1 -> diff=0, en_diff=0, tready=0, no handshake; tready=1 on the cycle after release.
2. tdata=16'hFFFF, tuser=8'h80 -> diff[1:0]:
   - sync 10 for 30 cycles, then 01 for 30;
   - 16 x (10 for 10, 01 for 10);
   - parity 1 (10, 01);
   - en_diff=2'b01 for exactly 400 cycles; diff[3:2]=00 throughout.
3. tdata=16'h0000, tuser=8'h00 -> sync 01 for 30 cycles, then 10 for 30; each bit is 01 then 10; parity 1; total 400 cycles.
4. Two words with tuser=8'h80, tvalid held -> en_diff[0] high for 800 contiguous cycles; second sync starts the cycle after word 1 parity ends; tready high only in cycle 400 of word 1.
5. tuser=8'h93, then another word -> en_diff[1] high 400 cycles, low 60 gap cycles; tready only in the last gap cycle; the next frame follows immediately.
6. Parity and bus checks:
   - tdata=16'h0001, tuser=8'hC0 -> parity half-bits 10,01 (inverted from normal 0).
   - tuser=8'hB0 with NUM_BUS=2 -> drop pulses once; en_diff stays 0.
   - arst at cycle 150 of a frame -> idle on the next cycle, tready=1 after release.

Source files
------------

// File: rtl/axis_1553_pkg.sv
// axis_1553_pkg: shared types and constants for the 1553 Manchester II encoder
package axis_1553_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;
  localparam logic [5:0] SYNC_HALF = 6'd6;
  localparam logic [5:0] DATA_HALF = 6'd32;
  localparam logic [5:0] PARITY_HALF = 6'd2;
  localparam int TU_SYNC = 7;
  localparam int TU_INV = 6;
  localparam int TU_SEL = 4;
  localparam int TU_GAP = 0;
  localparam logic [1:0] DIFF_HI = 2'b10;
  localparam logic [1:0] DIFF_LO = 2'b01;
  localparam logic [1:0] DIFF_IDLE = 2'b00;
  function automatic logic [1:0] manchester(input logic b, input logic second_half);
    return (b ^ second_half) ? DIFF_HI : DIFF_LO;
  endfunction
endpackage

// File: rtl/mil1553_halfbit_tick.sv
// mil1553_halfbit_tick: half-bit cycle counter with phase-position flags
module mil1553_halfbit_tick #(
  parameter int H = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [5:0] len,
  output logic       tick,
  output logic       last,
  output logic       pre_last,
  output logic [5:0] half
);
  localparam int CW = $clog2(H);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] half_q, half_d;
  // tick closes a half-bit; last/pre_last mark the final and penultimate cycle of the phase
  always_comb begin
    tick = cnt_q == CW'(H - 1);
    last = tick && half_q == len - 6'd1;
    pre_last = cnt_q == CW'(H - 2) && half_q == len - 6'd1;
    cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
    half_d = (clear || last) ? '0 : tick ? half_q + 6'd1 : half_q;
    half = half_q;
  end
  // counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      half_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      half_q <= half_d;
    end
  end
endmodule

// File: rtl/axis_1553_encoder_mc.sv
// axis_1553_encoder_mc: AXI-Stream to multi-bus MIL-STD-1553 Manchester II encoder
module axis_1553_encoder_mc
  import axis_1553_pkg::*;
#(
  parameter int clock_speed = 20000000,
  parameter int data_rate = 1000000,
  parameter int NUM_BUS = 2
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [15:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic [7:0]           s_axis_tuser,
  output logic                 s_axis_tready,
  output logic [2*NUM_BUS-1:0] diff,
  output logic [NUM_BUS-1:0]   en_diff,
  output logic                 drop
);
  localparam int H = clock_speed / (2 * data_rate);
  if (clock_speed % (2 * data_rate) != 0 || H < 2) begin : g_bad_rate
    $error("clock_speed/(2*data_rate) must be an integer >= 2");
  end
  if (NUM_BUS < 1 || NUM_BUS > 4) begin : g_bad_bus
    $error("NUM_BUS must be 1..4");
  end
  state_t state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [7:0] user_q, user_d;
  logic [2*NUM_BUS-1:0] diff_q, diff_d;
  logic [NUM_BUS-1:0] en_q, en_d;
  logic tready_q, tready_d, drop_q, drop_d;
  logic tick, last, pre_last, accept, bad, start, active, bit_v;
  logic [5:0] half, half_nxt, len;
  logic [3:0] gap;
  logic [1:0] sym;
  assign gap = user_q[TU_GAP +: 4];
  assign len = state_q == SYNC ? SYNC_HALF : state_q == DATA ? DATA_HALF :
               state_q == PARITY ? PARITY_HALF : state_q == GAP ? {1'b0, gap, 1'b0} : SYNC_HALF;
  mil1553_halfbit_tick #(.H(H)) u_tick (
    .clk(aclk),
    .rst(arst),
    .clear(state_q == IDLE),
    .len(len),
    .tick(tick),
    .last(last),
    .pre_last(pre_last),
    .half(half)
  );
  // next state and the symbol to drive in the following cycle, so outputs stay registered
  always_comb begin
    accept = s_axis_tvalid && tready_q;
    bad = int'(s_axis_tuser[TU_SEL +: 2]) >= NUM_BUS;
    start = accept && !bad;
    drop_d = accept && bad;
    data_d = start ? s_axis_tdata : data_q;
    user_d = start ? s_axis_tuser : user_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SYNC : IDLE;
      SYNC:    state_d = last ? DATA : SYNC;
      DATA:    state_d = last ? PARITY : DATA;
      PARITY:  state_d = !last ? PARITY : start ? SYNC : gap != 4'd0 ? GAP : IDLE;
      GAP:     state_d = !last ? GAP : start ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase
    half_nxt = tick ? (last ? 6'd0 : half + 6'd1) : half;
    bit_v = state_d == DATA ? data_d[4'd15 - half_nxt[4:1]] : (~^data_d) ^ user_d[TU_INV];
    sym = state_d == SYNC ? (((half_nxt < 6'd3) ^ !user_d[TU_SYNC]) ? DIFF_HI : DIFF_LO)
                          : manchester(bit_v, half_nxt[0]);
    active = state_d == SYNC || state_d == DATA || state_d == PARITY;
    for (int b = 0; b < NUM_BUS; b++) begin
      diff_d[2*b +: 2] = (active && user_d[TU_SEL +: 2] == 2'(b)) ? sym : DIFF_IDLE;
      en_d[b] = active && user_d[TU_SEL +: 2] == 2'(b);
    end
    tready_d = state_d == IDLE || (pre_last && ((state_q == PARITY && gap == 4'd0) || state_q == GAP));
  end
  // registered FSM state, latched word and outputs
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      data_q <= '0;
      user_q <= '0;
      diff_q <= '0;
      en_q <= '0;
      tready_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      user_q <= user_d;
      diff_q <= diff_d;
      en_q <= en_d;
      tready_q <= tready_d;
      drop_q <= drop_d;
    end
  end
  assign s_axis_tready = tready_q;
  assign diff = diff_q;
  assign en_diff = en_q;
  assign drop = drop_q;
endmodule

// File: tb/tb_axis_1553_encoder_mc.sv
// tb_axis_1553_encoder_mc: directed self-checking bench for the multi-bus 1553 encoder
module tb_axis_1553_encoder_mc;
  logic clk = 1'b0;
  logic arst, tvalid, tready, drop;
  logic [15:0] tdata;
  logic [7:0] tuser;
  logic [3:0] diff;
  logic [1:0] en_diff;
  logic [3:0] p0, p1;
  int checks = 0;
  int failures = 0;

  axis_1553_encoder_mc #(.clock_speed(20000000), .data_rate(1000000), .NUM_BUS(2)) dut (
    .aclk(clk),
    .arst(arst),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tuser(tuser),
    .s_axis_tready(tready),
    .diff(diff),
    .en_diff(en_diff),
    .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sym(input logic [15:0] d, input logic [7:0] u, input int k);
    int h;
    logic b;
    h = k / 10;
    if (h < 6) return ((h < 3) == u[7]) ? 2'b10 : 2'b01;
    if (h < 38) b = d[15 - (h - 6) / 2];
    else b = ~(^d) ^ u[6];
    return ((h % 2 == 0) == b) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic frame_check(input logic [15:0] d, input logic [7:0] u, input string tag,
                             output logic [3:0] q0, output logic [3:0] q1);
    int bad = 0;
    int first = -1;
    logic [7:0] fo = '0;
    logic [7:0] fe = '0;
    q0 = '0;
    q1 = '0;
    for (int k = 0; k < 400; k++) begin
      logic [1:0] s;
      logic [7:0] e;
      s = exp_sym(d, u, k);
      e = {u[4] ? {s, 2'b00} : {2'b00, s}, u[4] ? 2'b10 : 2'b01, (k == 399) && (u[3:0] == 4'd0), 1'b0};
      if (k == 380) q0 = diff;
      if (k == 390) q1 = diff;
      if ({diff, en_diff, tready, drop} !== e) begin
        if (bad == 0) begin
          first = k;
          fo = {diff, en_diff, tready, drop};
          fe = e;
        end
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    assert (bad === 0) else begin
      failures++;
      $error("FAIL %s: %0d bad cycles, first at k=%0d got %b expected %b", tag, bad, first, fo, fe);
    end
  endtask

  task automatic gap_check(input int n, input string tag);
    int bad = 0;
    int first = -1;
    for (int j = 0; j < n; j++) begin
      if ({diff, en_diff, tready, drop} !== {6'b0, j == n - 1, 1'b0}) begin
        if (bad == 0) first = j;
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    assert (bad === 0) else begin
      failures++;
      $error("FAIL %s: %0d bad gap cycles, first at j=%0d got %0d expected 0", tag, bad, first, bad);
    end
  endtask

  initial begin
    arst = 1'b1;
    tvalid = 1'b1;
    tdata = 16'h1234;
    tuser = 8'h80;
    repeat (5) @(negedge clk);
    chk("reset", {diff, en_diff, tready, drop}, 8'b0000_00_0_0);
    arst = 1'b0;
    tvalid = 1'b0;
    @(negedge clk);
    chk("release", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'hFFFF;
    tuser = 8'h80;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    frame_check(16'hFFFF, 8'h80, "frame_ffff", p0, p1);
    chk("idle_ffff", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'h0000;
    tuser = 8'h00;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    frame_check(16'h0000, 8'h00, "frame_0000", p0, p1);
    chk("idle_0000", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'h1234;
    tuser = 8'h80;
    tvalid = 1'b1;
    @(negedge clk);
    tdata = 16'hA5C3;
    frame_check(16'h1234, 8'h80, "b2b_word1", p0, p1);
    tvalid = 1'b0;
    frame_check(16'hA5C3, 8'h80, "b2b_word2", p0, p1);
    chk("idle_b2b", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'h6B1E;
    tuser = 8'h93;
    tvalid = 1'b1;
    @(negedge clk);
    tdata = 16'h8001;
    tuser = 8'h80;
    frame_check(16'h6B1E, 8'h93, "gap_word1", p0, p1);
    gap_check(60, "gap_60");
    tvalid = 1'b0;
    frame_check(16'h8001, 8'h80, "gap_word2", p0, p1);
    chk("idle_gap", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'h0001;
    tuser = 8'hC0;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    frame_check(16'h0001, 8'hC0, "frame_inv_par", p0, p1);
    chk("parity_halves", {p0, p1}, 8'b0010_0001);
    tdata = 16'h5555;
    tuser = 8'hB0;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    chk("drop_pulse", {diff, en_diff, tready, drop}, 8'b0000_00_1_1);
    @(negedge clk);
    chk("drop_once", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    repeat (5) @(negedge clk);
    chk("drop_no_tx", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    tdata = 16'hBEEF;
    tuser = 8'h80;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_frame_en", {6'b0, en_diff}, 8'h01);
    arst = 1'b1;
    @(negedge clk);
    chk("arst_idle", {diff, en_diff, tready, drop}, 8'b0000_00_0_0);
    arst = 1'b0;
    @(negedge clk);
    chk("arst_release", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    repeat (20) @(negedge clk);
    chk("no_resume", {diff, en_diff, tready, drop}, 8'b0000_00_1_0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
